rwmem_arbiter: RTL and testbench
================================

Name: rwmem_arbiter

Overview:
- Two-port arbiter and sequencer for the shared read/write data memory (rwmem).
- Requester 0 is the fetch/refill side and requester 1 is the load/store side.
- Serialises one transaction at a time onto the memory's ENABLE/READNOTWRITE/ADDRESS/data-ready handshake.
- Returns read data, completion and timeout error per requester. Sits between the DLX memory stage/cache and the rwmem model.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 64, memory data width
TIMEOUT_CYCLES, 16, max cycles in ACCESS before aborting with error (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req0_valid  in  1  requester 0 request
req0_rnw  in  1  1=read, 0=write
req0_addr  in  ADDR_WIDTH  address
req0_wdata  in  DATA_WIDTH  write data
req0_accept  out  1  one-cycle pulse: request latched
req0_done  out  1  one-cycle pulse: transaction finished
req0_err  out  1  valid with req0_done: timeout
req0_rdata  out  DATA_WIDTH  read data, valid with req0_done on reads
req1_valid, req1_rnw, req1_addr, req1_wdata, req1_accept, req1_done, req1_err, req1_rdata  as requester 0
mem_enable  out  1  memory ENABLE
mem_rnw  out  1  memory READNOTWRITE
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  data driven toward memory
mem_drive  out  1  tri-state enable for mem_wdata onto memory data bus
mem_rdata  in  DATA_WIDTH  data bus as seen from memory
mem_data_ready  in  1  memory DATA_READY
busy  out  1  state != IDLE
grant_id  out  1  requester owning current transaction

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, rr pointer=1.
- Reset values: every output is 0, including rdata registers. Any in-flight transaction is dropped silently, with no done pulse; mem_enable falls immediately.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any valid, choose winner per arbitration policy.
  - Latch winner's rnw/addr/wdata; set grant_id; pulse winner's accept this cycle.
  - Next state: ACCESS.
  - The losing requester sees no accept and must hold valid.
- ACCESS:
  - mem_enable=1, mem_rnw/mem_addr from latch, mem_drive=1 iff write, mem_wdata=latched wdata.
  - Latched values are stable for the whole state; requester inputs are ignored.
  - Timeout counter increments each cycle.
  - mem_data_ready sampled 1: if read, capture mem_rdata into the granted rdata register. Next state: RESP, err=0.
  - Else if counter == TIMEOUT_CYCLES-1: next state RESP, err=1. The rdata register is unchanged.
- RESP:
  - mem_enable=0 and mem_drive=0. This mandatory idle gap clears the memory's internal delay counter.
  - Pulse granted done and err (err only on timeout). Clear counter.
  - Next state: IDLE.
- Latency: accept to done = (cycles until mem_data_ready) + 1. Minimum request-to-request spacing = 3 cycles.
- mem_data_ready is ignored in IDLE and RESP.
- rdata holds its last value until overwritten by a later read for that requester. Writes never modify rdata.
- accept, done and err for the non-granted requester stay 0.
- valid deasserted after accept: no effect; the transaction completes.
- busy = (state != IDLE).

Optional Feature:
Macro RWMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous valid, the requester not granted last wins.
  - The rr pointer updates on each accept. Its reset value makes requester 0 win the first tie.
- Undefined: fixed priority; requester 0 always wins ties. The rr pointer logic is absent.
- A lone valid requester is always granted in both modes.

Test Plan:
- Read, memory model asserting ready 3 cycles after enable: req0 read addr 0x10, memory returns 0xDEADBEEF_CAFEF00D -> accept cycle 0, mem_enable cycles 1-3, done cycle 4, req0_rdata=0xDEADBEEF_CAFEF00D, err=0, mem_enable=0 in cycle 4.
- Write: req1 write addr 0x20, data 0x1122334455667788 -> mem_drive=1 and mem_rnw=0 throughout ACCESS, mem_wdata stable, req1_done pulses once, req1_rdata unchanged.
- Simultaneous valid, reads to 0x0 and 0x4, both held: without macro -> req0 served, then req0 again if still valid. With RWMEM_ARB_RR_EN -> req0, then req1, alternating.
- Timeout: TIMEOUT_CYCLES=4, memory never readies -> mem_enable high exactly 4 cycles, then done=1 and err=1, rdata unchanged, busy=0 next cycle.
- Reset mid-ACCESS: rst low for 1 cycle during a read -> mem_enable, busy and all pulses 0 immediately, no done. A subsequent request completes normally.
- Back-to-back: req0 held valid for 3 reads -> mem_enable low for at least 2 cycles between transactions (RESP + IDLE), 3 done pulses.

Source files
------------

// File: rtl/rwmem_arbiter.sv
// rwmem_arbiter: two-requester arbiter and sequencer for the shared rwmem.
// Requester 0 is fetch/refill and requester 1 is load/store. One transaction
// is carried at a time through IDLE -> ACCESS -> RESP.
// Build option: define RWMEM_ARB_RR_EN for round-robin tie-breaking; without
// it, requester 0 wins every tie.
`timescale 1ns/1ps
module rwmem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_rnw,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_accept,
    output logic                  req0_done,
    output logic                  req0_err,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_rnw,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_accept,
    output logic                  req1_done,
    output logic                  req1_err,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  mem_enable,
    output logic                  mem_rnw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_drive,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_data_ready,
    output logic                  busy,
    output logic                  grant_id
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  rnw_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  grant_reg;

    // Requester inputs gathered into vectors so the winner can index them.
    logic [1:0]            valid_vec;
    logic [1:0]            rnw_vec;
    logic [ADDR_WIDTH-1:0] addr_vec  [2];
    logic [DATA_WIDTH-1:0] wdata_vec [2];

    logic [1:0]            accept_vec;
    logic [1:0]            done_vec;
    logic [1:0]            err_vec;
    logic [DATA_WIDTH-1:0] rdata_vec [2];

    logic winner;
    logic any_valid;
    logic in_idle;
    logic in_access;
    logic timeout_hit;
    logic finish;

    assign valid_vec    = {req1_valid, req0_valid};
    assign rnw_vec      = {req1_rnw, req0_rnw};
    assign addr_vec[0]  = req0_addr;
    assign addr_vec[1]  = req1_addr;
    assign wdata_vec[0] = req0_wdata;
    assign wdata_vec[1] = req1_wdata;

    assign any_valid   = |valid_vec;
    assign in_idle     = (state_reg == ST_IDLE);
    assign in_access   = (state_reg == ST_ACCESS);
    assign timeout_hit = (cnt_reg == CNT_LAST);
    // A transaction ends on data-ready, or on the last permitted ACCESS cycle.
    assign finish      = in_access & (mem_data_ready | timeout_hit);

`ifdef RWMEM_ARB_RR_EN
    logic rr_last_reg;  // requester granted most recently; reset favours req0

    // Remember who was granted so the other side wins the next tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_reg <= 1'b1;
        end else if (in_idle && any_valid) begin
            rr_last_reg <= winner;
        end
    end
`endif

    // Pick the requester to serve; a lone valid requester always wins.
    always_comb begin
        winner = 1'b0;
        if (valid_vec == 2'b10) begin
            winner = 1'b1;
        end else if (valid_vec == 2'b11) begin
`ifdef RWMEM_ARB_RR_EN
            winner = ~rr_last_reg;
`else
            winner = 1'b0;
`endif
        end
    end

    // Main sequencer: latch the request, run the memory handshake, then one idle RESP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            rnw_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            grant_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_valid) begin
                        rnw_reg   <= rnw_vec[winner];
                        addr_reg  <= addr_vec[winner];
                        wdata_reg <= wdata_vec[winner];
                        grant_reg <= winner;
                        state_reg <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (finish) begin
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic                  mine;
            logic                  done_reg;
            logic                  err_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;

            assign mine = (grant_reg == 1'(gi));

            // Per-requester completion flags and read-data holding register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    done_reg <= finish & mine;
                    err_reg  <= finish & mine & ~mem_data_ready;
                    if (finish && mine && mem_data_ready && rnw_reg) begin
                        rdata_reg <= mem_rdata;
                    end
                end
            end

            // Accept is combinational in IDLE so the latch happens on this very edge.
            assign accept_vec[gi] = rst & in_idle & any_valid & (winner == 1'(gi));
            assign done_vec[gi]   = done_reg;
            assign err_vec[gi]    = err_reg;
            assign rdata_vec[gi]  = rdata_reg;
        end
    endgenerate

    assign req0_accept = accept_vec[0];
    assign req1_accept = accept_vec[1];
    assign req0_done   = done_vec[0];
    assign req1_done   = done_vec[1];
    assign req0_err    = err_vec[0];
    assign req1_err    = err_vec[1];
    assign req0_rdata  = rdata_vec[0];
    assign req1_rdata  = rdata_vec[1];

    // Memory side is only driven in ACCESS; RESP gives the mandatory low-enable gap.
    assign mem_enable = in_access;
    assign mem_rnw    = in_access & rnw_reg;
    assign mem_drive  = in_access & ~rnw_reg;
    assign mem_addr   = in_access ? addr_reg : '0;
    assign mem_wdata  = in_access ? wdata_reg : '0;
    assign busy       = ~in_idle;
    assign grant_id   = grant_reg;

endmodule

// File: tb/tb_rwmem_arbiter.sv
`timescale 1ns/1ps
module tb_rwmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0, req0_rnw = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req0_accept, req0_done, req0_err;
    logic [DW-1:0] req0_rdata;
    logic          req1_valid = 1'b0, req1_rnw = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req1_accept, req1_done, req1_err;
    logic [DW-1:0] req1_rdata;
    logic          mem_enable, mem_rnw, mem_drive;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_data_ready = 1'b0;
    logic          busy, grant_id;

    rwmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rnw(req0_rnw), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_accept(req0_accept), .req0_done(req0_done),
        .req0_err(req0_err), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_rnw(req1_rnw), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_accept(req1_accept), .req1_done(req1_done),
        .req1_err(req1_err), .req1_rdata(req1_rdata),
        .mem_enable(mem_enable), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_drive(mem_drive), .mem_rdata(mem_rdata),
        .mem_data_ready(mem_data_ready), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          rnw;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          lat;
        bit          err;
        logic [63:0] rdata;
    } txn_t;

    txn_t sb_q[$];
    txn_t bus_q[$];
    int   acc_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [63:0] env_mem [8];   // contents the memory model actually holds
    logic [63:0] ref_mem [8];   // contents the reference model expects
    logic [63:0] ref_rd  [2];   // expected value of each rdata register

    bit          pend    [2];
    bit          p_rnw   [2];
    logic [31:0] p_addr  [2];
    logic [63:0] p_wdata [2];
    int          p_lat   [2];
    int          last_grant = 1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_true(input string name, input bit ok, input string detail);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
        end
    endtask

    function automatic int eff_lat(input int lat);
        return (lat < TO) ? lat : TO;
    endfunction

    // ---------------- memory model and response monitor ----------------
    txn_t cur;
    bit   in_acc = 0;
    bit   have_prev = 0;
    int   ecnt = 0;
    int   low_cnt = 0;
    int   did;
    int   acc_cyc;
    txn_t exp_t;

    always @(negedge clk) begin
        if (!rst) begin
            in_acc = 0; have_prev = 0; ecnt = 0; low_cnt = 0;
            mem_data_ready = 1'b0;
        end else begin
            if (mem_enable) begin
                if (!in_acc) begin
                    in_acc = 1;
                    ecnt = 0;
                    if (have_prev)
                        check_true("enable_gap", low_cnt >= 2,
                                   $sformatf("enable low %0d cycles, need >=2", low_cnt));
                    if (bus_q.size() == 0) begin
                        check_true("bus_item", 1'b0, "memory enabled with no accepted transaction");
                        cur.id = 0; cur.rnw = 1; cur.addr = '0; cur.wdata = '0;
                        cur.lat = 1000; cur.err = 1; cur.rdata = '0;
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end
                ecnt++;
                check("mem_addr", mem_addr, cur.addr);
                check("mem_rnw", mem_rnw, cur.rnw);
                check("mem_drive", mem_drive, !cur.rnw);
                check("grant_id", grant_id, cur.id);
                if (!cur.rnw) check("mem_wdata", mem_wdata, cur.wdata);
                mem_data_ready = (ecnt >= cur.lat);
                if (mem_data_ready) mem_rdata = env_mem[mem_addr[5:3]];
                else                mem_rdata = {$urandom, $urandom};
                if (mem_data_ready && !mem_rnw && mem_drive)
                    env_mem[mem_addr[5:3]] = mem_wdata;
            end else begin
                if (in_acc) begin
                    check("enable_cycles", ecnt, eff_lat(cur.lat));
                    in_acc = 0;
                    have_prev = 1;
                    low_cnt = 0;
                end
                low_cnt++;
                mem_data_ready = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end

            if (req0_done || req1_done) begin
                did = req1_done ? 1 : 0;
                check("single_done", req0_done & req1_done, 1'b0);
                if (sb_q.size() == 0) begin
                    check_true("unexpected_done", 1'b0, $sformatf("done on requester %0d with nothing outstanding", did));
                end else begin
                    exp_t = sb_q.pop_front();
                    acc_cyc = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                    check("done_id", did, exp_t.id);
                    check("err", did ? req1_err : req0_err, exp_t.err);
                    check("other_err", did ? req0_err : req1_err, 1'b0);
                    check("rdata", did ? req1_rdata : req0_rdata, exp_t.rdata);
                    check("latency", cyc - acc_cyc, eff_lat(exp_t.lat) + 1);
                    $display("txn req%0d %s addr=%h lat=%0d err=%0d rdata=%h", did,
                             exp_t.rnw ? "RD" : "WR", exp_t.addr, exp_t.lat,
                             did ? req1_err : req0_err, did ? req1_rdata : req0_rdata);
                end
            end else begin
                check("err_without_done", req0_err | req1_err, 1'b0);
            end
            check("busy", busy, mem_enable | req0_done | req1_done);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_inputs();
        req0_valid = pend[0]; req0_rnw = p_rnw[0]; req0_addr = p_addr[0]; req0_wdata = p_wdata[0];
        req1_valid = pend[1]; req1_rnw = p_rnw[1]; req1_addr = p_addr[1]; req1_wdata = p_wdata[1];
    endtask

    task automatic set_req(input int r, input bit rnw, input logic [31:0] addr,
                           input logic [63:0] wd, input int lat);
        pend[r] = 1; p_rnw[r] = rnw; p_addr[r] = addr; p_wdata[r] = wd; p_lat[r] = lat;
    endtask

    task automatic rand_req(input int r);
        set_req(r, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 3,
                {$urandom, $urandom}, $urandom_range(1, 6));
    endtask

    // Present pending requests, predict the winner, and wait for the accept.
    task automatic step(output bit ok);
        int   w;
        int   a;
        int   idx;
        bit   got;
        txn_t t;
        drive_inputs();
        if (pend[0] && pend[1]) begin
`ifdef RWMEM_ARB_RR_EN
            w = (last_grant == 0) ? 1 : 0;
`else
            w = 0;
`endif
        end else begin
            w = pend[1] ? 1 : 0;
        end
        t.id = w; t.rnw = p_rnw[w]; t.addr = p_addr[w]; t.wdata = p_wdata[w]; t.lat = p_lat[w];
        idx = int'(t.addr[5:3]);
        t.err = (t.lat > TO);
        if (!t.err && t.rnw)  ref_rd[w] = ref_mem[idx];
        if (!t.err && !t.rnw) ref_mem[idx] = t.wdata;
        t.rdata = ref_rd[w];
        sb_q.push_back(t);
        bus_q.push_back(t);
        got = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req0_accept || req1_accept) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check_true("accept_wait", 1'b0, "no accept within 40 cycles");
            ok = 0;
            return;
        end
        a = req1_accept ? 1 : 0;
        check("accept_both", req0_accept & req1_accept, 1'b0);
        check("accept_id", a, w);
        acc_q.push_back(cyc);
        last_grant = a;
        pend[a] = 0;
        @(negedge clk);
        drive_inputs();
        ok = 1;
    endtask

    bit ok;
    int waitc;

    initial begin
        for (int i = 0; i < 8; i++) begin
            env_mem[i] = {32'hA5A5_0000 + 32'(i), 32'h5A5A_1000 + 32'(i)};
            ref_mem[i] = env_mem[i];
        end
        env_mem[2] = 64'hDEADBEEF_CAFEF00D;
        ref_mem[2] = 64'hDEADBEEF_CAFEF00D;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 0; p_rnw[r] = 0; p_addr[r] = '0; p_wdata[r] = '0; p_lat[r] = 1;
        end

        // Reset state, with both requesters asserting valid.
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_accept", {req1_accept, req0_accept}, 2'b00);
        check("rst_done", {req1_done, req0_done}, 2'b00);
        check("rst_err", {req1_err, req0_err}, 2'b00);
        check("rst_rdata0", req0_rdata, 64'd0);
        check("rst_rdata1", req1_rdata, 64'd0);
        check("rst_mem", {mem_enable, mem_rnw, mem_drive, busy, grant_id}, 5'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a read: everything drops at once, no done.
        req0_valid = 1'b1; req0_rnw = 1'b1; req0_addr = 32'h0;
        cur.id = 0;
        begin
            txn_t t;
            t.id = 0; t.rnw = 1; t.addr = 32'h0; t.wdata = '0; t.lat = 50; t.err = 1; t.rdata = '0;
            bus_q.push_back(t);
        end
        #1;
        check("midrst_accept", req0_accept, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_outputs", {mem_enable, busy, req0_done, req1_done, req0_accept, req1_accept}, 6'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        last_grant = 1;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        bus_q.delete();
        repeat (6) @(negedge clk);

        // Directed transactions.
        set_req(0, 1'b1, 32'h10, 64'h0, 3);                   step(ok);
        set_req(1, 1'b0, 32'h20, 64'h11223344_55667788, 2);   step(ok);
        set_req(1, 1'b1, 32'h20, 64'h0, 1);                   step(ok);
        set_req(0, 1'b1, 32'h08, 64'h0, 9);                   step(ok);
        set_req(0, 1'b1, 32'h00, 64'h0, 2);
        set_req(1, 1'b1, 32'h04, 64'h0, 2);                   step(ok);
        if (!pend[0]) set_req(0, 1'b1, 32'h00, 64'h0, 1);
        step(ok);
        if (!pend[0]) set_req(0, 1'b1, 32'h00, 64'h0, 1);
        if (!pend[1]) set_req(1, 1'b1, 32'h04, 64'h0, 1);
        step(ok);

        // Randomized traffic with held and overlapping requests.
        for (int n = 0; n < 150 && ok; n++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 1) == 1) rand_req(r);
            if (!pend[0] && !pend[1]) rand_req(int'($urandom_range(0, 1)));
            step(ok);
        end
        while (ok && (pend[0] || pend[1])) step(ok);

        waitc = 0;
        while (sb_q.size() != 0 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check_true("drain", sb_q.size() == 0,
                   $sformatf("%0d transactions never completed", sb_q.size()));
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
